// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave block.
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  typedef enum logic {IDLE, SHIFT} spi_slave_state_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the parallel byte-side handshake of the slave.
interface spi_slave_if #(parameter int WIDTH = spi_pkg::SPI_WIDTH);
  logic             sclk;
  logic             mosi;
  logic             ss_n;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_taken;
  logic [WIDTH-1:0] rx_data;
  logic             rx_done;
  logic             busy;
  modport slave (
    input  sclk, mosi, ss_n, tx_data,
    output miso, miso_oe, tx_taken, rx_data, rx_done, busy
  );
  modport master (
    output sclk, mosi, ss_n, tx_data,
    input  miso, miso_oe, tx_taken, rx_data, rx_done, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer bank for asynchronous single-bit inputs.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled mode-0 SPI slave, one rx byte in and one tx byte out per transfer.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic             sclk_s, mosi_s, ss_n_s, sclk_rise, sclk_fall;
  spi_slave_state_t state_q, state_d;
  logic             sclk_dly_q, sclk_dly_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_done_q, rx_done_d;
  logic             tx_taken_q, tx_taken_d;
  logic             reload_q, reload_d;
  sync_2ff #(.W(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({bus.sclk, bus.mosi, bus.ss_n}),
    .q     ({sclk_s, mosi_s, ss_n_s})
  );
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  // Deselect has priority over every sclk edge, so a last-bit rise racing ss_n is dropped.
  always_comb begin
    state_d    = state_q;
    sclk_dly_d = sclk_s;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    tx_taken_d = 1'b0;
    reload_d   = reload_q;
    if (state_q == IDLE) begin
      bit_cnt_d = '0;
      if (!ss_n_s) begin
        tx_shift_d = bus.tx_data;
        tx_taken_d = 1'b1;
        reload_d   = 1'b0;
        state_d    = SHIFT;
      end
    end else if (ss_n_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
      if (bit_cnt_q == CW'(WIDTH - 1)) begin
        rx_data_d = rx_shift_d;
        rx_done_d = 1'b1;
        bit_cnt_d = '0;
        reload_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (sclk_fall) begin
      tx_shift_d = reload_q ? bus.tx_data : tx_shift_q << 1;
      tx_taken_d = reload_q;
      reload_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sclk_dly_q <= 1'b0;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      tx_taken_q <= 1'b0;
      reload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_dly_q <= sclk_dly_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      tx_taken_q <= tx_taken_d;
      reload_q   <= reload_d;
    end
  end
  assign bus.busy     = (state_q == SHIFT);
  assign bus.miso_oe  = (state_q == SHIFT);
  assign bus.miso     = (state_q == SHIFT) ? tx_shift_q[WIDTH-1] : 1'b0;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_done  = rx_done_q;
  assign bus.tx_taken = tx_taken_q;
endmodule
